// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} fetch_state_t;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, one-entry output buffer to decode.
// Response-to-instr_valid latency is 1 cycle; decode backpressure holds the buffer and stalls fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  output logic                   o_pc_write_en,
  output logic [ADDR_WIDTH-1:0]  o_next_pc,
  output logic                   o_mem_req_valid,
  input  logic                   i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] i_mem_resp_data,
  input  logic                   i_mem_resp_err,
  input  logic                   i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_instr_valid,
  input  logic                   i_instr_ready,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_instr_pc,
  output logic                   o_fetch_fault
);

  fetch_state_t           state_q, state_d;
  logic                   kill_q, kill_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   buf_vld_q, buf_vld_d;
  logic [INSTR_WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic [ADDR_WIDTH-1:0]  buf_pc_q, buf_pc_d;
  logic                   buf_fault_q, buf_fault_d;

  logic aligned, req_vld, req_fire, buf_take;

  assign aligned  = (i_pc[1:0] == 2'b00);
  assign req_vld  = !arst && (state_q == S_REQ) && aligned;
  assign req_fire = req_vld && i_mem_req_ready;
  assign buf_take = buf_vld_q && i_instr_ready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= S_REQ;
      kill_q      <= 1'b0;
      pc_q        <= '0;
      buf_vld_q   <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      buf_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      pc_q        <= pc_d;
      buf_vld_q   <= buf_vld_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_fault_q <= buf_fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    pc_d        = pc_q;
    buf_vld_d   = buf_vld_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_fault_d = buf_fault_q;
    unique case (state_q)
      S_REQ: begin
        if (!aligned) begin
          buf_vld_d   = 1'b1;
          buf_instr_d = '0;
          buf_pc_d    = i_pc;
          buf_fault_d = 1'b1;
          state_d     = S_FAULT;
        end else if (req_fire) begin
          pc_d    = i_pc;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            buf_vld_d   = 1'b1;
            buf_instr_d = i_mem_resp_data;
            buf_pc_d    = pc_q;
            buf_fault_d = i_mem_resp_err;
            state_d     = i_mem_resp_err ? S_FAULT : S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (buf_take) begin
          buf_vld_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_FAULT: begin
        if (buf_take) buf_vld_d = 1'b0;
      end
    endcase
    // Redirect overrides everything above; an in-flight request must have its response killed.
    if (i_redirect_valid) begin
      buf_vld_d = 1'b0;
      case (state_q)
        S_WAIT: begin
          state_d = i_mem_resp_valid ? S_REQ : S_WAIT;
          kill_d  = !i_mem_resp_valid;
        end
        S_REQ: begin
          state_d = req_fire ? S_WAIT : S_REQ;
          kill_d  = req_fire;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    o_mem_req_valid = req_vld;
    o_mem_addr      = arst ? '0 : i_pc;
    o_pc_write_en   = !arst && (i_redirect_valid ||
                      (state_q == S_WAIT && i_mem_resp_valid && !kill_q && !i_mem_resp_err));
    o_next_pc       = '0;
    if (o_pc_write_en)
      o_next_pc = i_redirect_valid ? i_redirect_pc : pc_q + ADDR_WIDTH'(INSTR_BYTES);
    o_instr_valid   = buf_vld_q;
    o_instr         = buf_instr_q;
    o_instr_pc      = buf_pc_q;
    o_fetch_fault   = buf_fault_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural PC register model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        arst;
  logic [63:0] i_pc;
  logic        o_pc_write_en;
  logic [63:0] o_next_pc;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [63:0] o_mem_addr;
  logic        i_mem_resp_valid;
  logic [31:0] i_mem_resp_data;
  logic        i_mem_resp_err;
  logic        i_redirect_valid;
  logic [63:0] i_redirect_pc;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [31:0] o_instr;
  logic [63:0] o_instr_pc;
  logic        o_fetch_fault;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.ADDR_WIDTH(64), .INSTR_WIDTH(32)) dut (
    .clk(clk), .arst(arst), .i_pc(i_pc),
    .o_pc_write_en(o_pc_write_en), .o_next_pc(o_next_pc),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_addr(o_mem_addr), .i_mem_resp_valid(i_mem_resp_valid),
    .i_mem_resp_data(i_mem_resp_data), .i_mem_resp_err(i_mem_resp_err),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready),
    .o_instr(o_instr), .o_instr_pc(o_instr_pc), .o_fetch_fault(o_fetch_fault)
  );

  always #5 clk = ~clk;

  // PC register: written by the fetch unit's write-enable pulse.
  always @(posedge clk or posedge arst) begin
    if (arst) i_pc <= 64'h3000_0000;
    else if (o_pc_write_en) i_pc <= o_next_pc;
  end

  // Advance one cycle; inputs are driven and outputs sampled 2ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    i_mem_req_ready = 1'b1; i_mem_resp_valid = 1'b0; i_mem_resp_data = '0; i_mem_resp_err = 1'b0;
    i_redirect_valid = 1'b0; i_redirect_pc = '0; i_instr_ready = 1'b0;
    repeat (3) tick();
    #1;
    checks++; if (o_mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", o_mem_req_valid); end
    checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", o_instr_valid); end
    checks++; if (o_pc_write_en !== 1'b0) begin failures++; $display("FAIL reset_pc_write_en got=%b exp=0", o_pc_write_en); end
    checks++; if (o_fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", o_fetch_fault); end
    tick();
    arst = 1'b0;
  endtask

  task automatic test_first_req();
    #1;
    checks++; if (o_mem_req_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%b exp=1", o_mem_req_valid); end
    checks++; if (o_mem_addr !== 64'h3000_0000) begin failures++; $display("FAIL first_req_addr got=%h exp=%h", o_mem_addr, 64'h3000_0000); end
    tick();
    i_mem_req_ready = 1'b0;
    #1;
    checks++; if (o_mem_req_valid !== 1'b0) begin failures++; $display("FAIL wait_no_req got=%b exp=0", o_mem_req_valid); end
  endtask

  task automatic test_resp();
    tick();
    i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'h0000_0013;
    #1;
    checks++; if (o_pc_write_en !== 1'b1) begin failures++; $display("FAIL resp_pc_we got=%b exp=1", o_pc_write_en); end
    checks++; if (o_next_pc !== 64'h3000_0004) begin failures++; $display("FAIL resp_next_pc got=%h exp=%h", o_next_pc, 64'h3000_0004); end
    checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL resp_early_valid got=%b exp=0", o_instr_valid); end
    tick();
    i_mem_resp_valid = 1'b0;
    #1;
    checks++; if (o_instr_valid !== 1'b1) begin failures++; $display("FAIL instr_valid got=%b exp=1", o_instr_valid); end
    checks++; if (o_instr !== 32'h0000_0013) begin failures++; $display("FAIL instr_data got=%h exp=%h", o_instr, 32'h13); end
    checks++; if (o_instr_pc !== 64'h3000_0000) begin failures++; $display("FAIL instr_pc got=%h exp=%h", o_instr_pc, 64'h3000_0000); end
    checks++; if (o_fetch_fault !== 1'b0) begin failures++; $display("FAIL instr_fault got=%b exp=0", o_fetch_fault); end
    checks++; if (i_pc !== 64'h3000_0004) begin failures++; $display("FAIL pc_updated got=%h exp=%h", i_pc, 64'h3000_0004); end
    checks++; if (o_pc_write_en !== 1'b0) begin failures++; $display("FAIL pc_we_pulse got=%b exp=0", o_pc_write_en); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      checks++; if (o_instr_valid !== 1'b1 || o_instr !== 32'h13 || o_instr_pc !== 64'h3000_0000)
        begin failures++; $display("FAIL hold_stable cyc=%0d got=%b/%h/%h exp=1/00000013/30000000", i, o_instr_valid, o_instr, o_instr_pc); end
      checks++; if (o_mem_req_valid !== 1'b0) begin failures++; $display("FAIL hold_no_req cyc=%0d got=%b exp=0", i, o_mem_req_valid); end
      tick();
      #1;
    end
    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;
    #1;
    checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL consume_valid got=%b exp=0", o_instr_valid); end
    checks++; if (o_mem_req_valid !== 1'b1) begin failures++; $display("FAIL next_req_valid got=%b exp=1", o_mem_req_valid); end
    checks++; if (o_mem_addr !== 64'h3000_0004) begin failures++; $display("FAIL next_req_addr got=%h exp=%h", o_mem_addr, 64'h3000_0004); end
  endtask

  task automatic test_redirect_wait();
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    i_redirect_valid = 1'b1; i_redirect_pc = 64'h3000_0100;
    #1;
    checks++; if (o_pc_write_en !== 1'b1 || o_next_pc !== 64'h3000_0100)
      begin failures++; $display("FAIL redir_wait_write got=%b/%h exp=1/%h", o_pc_write_en, o_next_pc, 64'h3000_0100); end
    tick();
    i_redirect_valid = 1'b0;
    #1;
    checks++; if (o_mem_req_valid !== 1'b0) begin failures++; $display("FAIL killed_wait_no_req got=%b exp=0", o_mem_req_valid); end
    tick();
    i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (o_pc_write_en !== 1'b0) begin failures++; $display("FAIL killed_resp_we got=%b exp=0", o_pc_write_en); end
    tick();
    i_mem_resp_valid = 1'b0;
    #1;
    checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL killed_resp_valid got=%b exp=0", o_instr_valid); end
    checks++; if (o_mem_req_valid !== 1'b1 || o_mem_addr !== 64'h3000_0100)
      begin failures++; $display("FAIL redir_req got=%b/%h exp=1/%h", o_mem_req_valid, o_mem_addr, 64'h3000_0100); end
  endtask

  task automatic test_fault();
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    i_mem_resp_valid = 1'b1; i_mem_resp_err = 1'b1; i_mem_resp_data = 32'h0000_1234;
    #1;
    checks++; if (o_pc_write_en !== 1'b0) begin failures++; $display("FAIL err_no_we got=%b exp=0", o_pc_write_en); end
    tick();
    i_mem_resp_valid = 1'b0; i_mem_resp_err = 1'b0;
    #1;
    checks++; if (o_instr_valid !== 1'b1 || o_fetch_fault !== 1'b1 || o_instr_pc !== 64'h3000_0100)
      begin failures++; $display("FAIL err_marker got=%b/%b/%h exp=1/1/%h", o_instr_valid, o_fetch_fault, o_instr_pc, 64'h3000_0100); end
    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (o_instr_valid !== 1'b0 || o_mem_req_valid !== 1'b0)
        begin failures++; $display("FAIL fault_idle cyc=%0d got=%b/%b exp=0/0", i, o_instr_valid, o_mem_req_valid); end
      tick();
    end
  endtask

  task automatic test_misaligned();
    i_redirect_valid = 1'b1; i_redirect_pc = 64'h3000_0102;
    #1;
    checks++; if (o_pc_write_en !== 1'b1 || o_next_pc !== 64'h3000_0102)
      begin failures++; $display("FAIL redir_fault_write got=%b/%h exp=1/%h", o_pc_write_en, o_next_pc, 64'h3000_0102); end
    tick();
    i_redirect_valid = 1'b0;
    #1;
    checks++; if (o_mem_req_valid !== 1'b0) begin failures++; $display("FAIL misaligned_no_req got=%b exp=0", o_mem_req_valid); end
    tick();
    #1;
    checks++; if (o_instr_valid !== 1'b1 || o_fetch_fault !== 1'b1 || o_instr_pc !== 64'h3000_0102 || o_instr !== 32'h0)
      begin failures++; $display("FAIL misaligned_marker got=%b/%b/%h/%h exp=1/1/%h/0", o_instr_valid, o_fetch_fault, o_instr_pc, o_instr, 64'h3000_0102); end
    checks++; if (o_mem_req_valid !== 1'b0) begin failures++; $display("FAIL misaligned_still_no_req got=%b exp=0", o_mem_req_valid); end
  endtask

  task automatic test_redirect_resp();
    // Redirect from S_FAULT while decode handshakes the marker: buffer must still flush.
    i_redirect_valid = 1'b1; i_redirect_pc = 64'h3000_0200; i_instr_ready = 1'b1;
    tick();
    i_redirect_valid = 1'b0; i_instr_ready = 1'b0;
    #1;
    checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL flush_on_handshake got=%b exp=0", o_instr_valid); end
    checks++; if (o_mem_req_valid !== 1'b1 || o_mem_addr !== 64'h3000_0200)
      begin failures++; $display("FAIL req_after_fault got=%b/%h exp=1/%h", o_mem_req_valid, o_mem_addr, 64'h3000_0200); end
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'h1111_1111;
    i_redirect_valid = 1'b1; i_redirect_pc = 64'h3000_0300;
    #1;
    checks++; if (o_pc_write_en !== 1'b1 || o_next_pc !== 64'h3000_0300)
      begin failures++; $display("FAIL redir_resp_write got=%b/%h exp=1/%h", o_pc_write_en, o_next_pc, 64'h3000_0300); end
    tick();
    i_mem_resp_valid = 1'b0; i_redirect_valid = 1'b0;
    #1;
    checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL redir_resp_dropped got=%b exp=0", o_instr_valid); end
    checks++; if (o_mem_req_valid !== 1'b1 || o_mem_addr !== 64'h3000_0300)
      begin failures++; $display("FAIL redir_resp_req got=%b/%h exp=1/%h", o_mem_req_valid, o_mem_addr, 64'h3000_0300); end
    // No stale kill: the next response must be delivered.
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'h0050_0093;
    #1;
    checks++; if (o_pc_write_en !== 1'b1 || o_next_pc !== 64'h3000_0304)
      begin failures++; $display("FAIL post_redir_write got=%b/%h exp=1/%h", o_pc_write_en, o_next_pc, 64'h3000_0304); end
    tick();
    i_mem_resp_valid = 1'b0;
    #1;
    checks++; if (o_instr_valid !== 1'b1 || o_instr !== 32'h0050_0093 || o_instr_pc !== 64'h3000_0300)
      begin failures++; $display("FAIL post_redir_instr got=%b/%h/%h exp=1/00500093/%h", o_instr_valid, o_instr, o_instr_pc, 64'h3000_0300); end
  endtask

  task automatic test_wrap();
    // Redirect from S_HOLD to the last word of the address space.
    i_redirect_valid = 1'b1; i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    i_redirect_valid = 1'b0;
    #1;
    checks++; if (o_instr_valid !== 1'b0) begin failures++; $display("FAIL hold_flush got=%b exp=0", o_instr_valid); end
    checks++; if (o_mem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_req_addr got=%h exp=fffffffffffffffc", o_mem_addr); end
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'h0000_0001;
    #1;
    checks++; if (o_pc_write_en !== 1'b1 || o_next_pc !== 64'h0)
      begin failures++; $display("FAIL wrap_next_pc got=%b/%h exp=1/0", o_pc_write_en, o_next_pc); end
    tick();
    i_mem_resp_valid = 1'b0;
    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;
  endtask

  task automatic test_redirect_accept();
    // Redirect in the same cycle as an accepted request: its response must be killed.
    #1;
    checks++; if (o_mem_req_valid !== 1'b1 || o_mem_addr !== 64'h0)
      begin failures++; $display("FAIL wrap_req got=%b/%h exp=1/0", o_mem_req_valid, o_mem_addr); end
    i_mem_req_ready = 1'b1; i_redirect_valid = 1'b1; i_redirect_pc = 64'h3000_0400;
    tick();
    i_mem_req_ready = 1'b0; i_redirect_valid = 1'b0;
    #1;
    checks++; if (o_mem_req_valid !== 1'b0) begin failures++; $display("FAIL accept_redir_wait got=%b exp=0", o_mem_req_valid); end
    i_mem_resp_valid = 1'b1; i_mem_resp_data = 32'hBAD0_BAD0;
    #1;
    checks++; if (o_pc_write_en !== 1'b0) begin failures++; $display("FAIL accept_redir_kill_we got=%b exp=0", o_pc_write_en); end
    tick();
    i_mem_resp_valid = 1'b0;
    #1;
    checks++; if (o_instr_valid !== 1'b0 || o_mem_req_valid !== 1'b1 || o_mem_addr !== 64'h3000_0400)
      begin failures++; $display("FAIL accept_redir_req got=%b/%b/%h exp=0/1/%h", o_instr_valid, o_mem_req_valid, o_mem_addr, 64'h3000_0400); end
  endtask

  initial begin
    test_reset();
    test_first_req();
    test_resp();
    test_hold();
    test_redirect_wait();
    test_fault();
    test_misaligned();
    test_redirect_resp();
    test_wrap();
    test_redirect_accept();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
